// File: rtl/up_cu.sv
// Control unit for the 8-bit accumulator processor: Start -> Fetch -> Decode -> Execute sequencing.
// Optional macro UP_CU_HALT_RELEASE_EN: Enter releases the HALT state back to Start.
module up_cu (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [2:0] IR,
  input  logic       Aeq0,
  input  logic       Apos,
  input  logic       Enter,
  output logic       IRload,
  output logic       JMPmux,
  output logic       PCload,
  output logic       Meminst,
  output logic       MemWr,
  output logic       Aload,
  output logic       Sub,
  output logic       Halt,
  output logic [1:0] Asel,
  output logic [3:0] outState
);

  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LDA    = 4'd8,
    S_STA    = 4'd9,
    S_ADD    = 4'd10,
    S_SUB    = 4'd11,
    S_IN     = 4'd12,
    S_JZ     = 4'd13,
    S_JPOS   = 4'd14,
    S_HALT   = 4'd15
  } state_t;

  state_t state;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= S_START;
    end else begin
      case (state)
        S_START:  state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        // execute-state codes are 8 + opcode
        S_DECODE: state <= state_t'({1'b1, IR});
        S_LDA, S_STA, S_ADD, S_SUB, S_JZ, S_JPOS:
          state <= S_START;
        S_IN:     state <= Enter ? S_START : S_IN;
`ifdef UP_CU_HALT_RELEASE_EN
        S_HALT:   state <= Enter ? S_START : S_HALT;
`else
        S_HALT:   state <= S_HALT;
`endif
        default:  state <= S_START;
      endcase
    end
  end

  always_comb begin
    IRload  = 1'b0;
    JMPmux  = 1'b0;
    PCload  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Halt    = 1'b0;
    Asel    = '0;
    case (state)
      S_FETCH: begin
        IRload = 1'b1;
        PCload = 1'b1;
      end
      S_DECODE: Meminst = 1'b1;
      S_LDA: begin
        Meminst = 1'b1;
        Asel    = 2'b10;
        Aload   = 1'b1;
      end
      S_STA: begin
        Meminst = 1'b1;
        MemWr   = 1'b1;
      end
      S_ADD: Aload = 1'b1;
      S_SUB: begin
        Aload = 1'b1;
        Sub   = 1'b1;
      end
      S_IN: begin
        Asel  = 2'b01;
        Aload = Enter;
      end
      S_JZ: begin
        JMPmux = 1'b1;
        PCload = Aeq0;
      end
      S_JPOS: begin
        JMPmux = 1'b1;
        PCload = Apos;
      end
      S_HALT: Halt = 1'b1;
      default: ;
    endcase
  end

  assign outState = state;

endmodule

// File: tb/tb_up_cu.sv
// Randomised scoreboard bench for up_cu: a per-instruction phase model queues expected
// state/control words and an independent monitor compares them against the DUT.
module tb_up_cu;

  logic       CLOCK, RESET;
  logic [2:0] IR;
  logic       Aeq0, Apos, Enter;
  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt;
  logic [1:0] Asel;
  logic [3:0] outState;

  up_cu dut (
    .CLOCK(CLOCK), .RESET(RESET), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
    .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload), .Meminst(Meminst),
    .MemWr(MemWr), .Aload(Aload), .Sub(Sub), .Halt(Halt), .Asel(Asel),
    .outState(outState)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic [9:0] ctl;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // control word: IRload JMPmux PCload Meminst MemWr Aload Sub Halt Asel[1:0]
  function automatic logic [9:0] mk(input logic irl, input logic jm, input logic pcl,
                                    input logic mi, input logic mw, input logic al,
                                    input logic sb, input logic hl, input logic [1:0] as);
    return {irl, jm, pcl, mi, mw, al, sb, hl, as};
  endfunction

  function automatic logic [9:0] exec_ctl(input int op, input logic en,
                                          input logic z, input logic p);
    case (op)
      0: return mk(0, 0, 0, 1, 0, 1, 0, 0, 2'b10);
      1: return mk(0, 0, 0, 1, 1, 0, 0, 0, 2'b00);
      2: return mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b00);
      3: return mk(0, 0, 0, 0, 0, 1, 1, 0, 2'b00);
      4: return mk(0, 0, 0, 0, 0, en, 0, 0, 2'b01);
      5: return mk(0, 1, z, 0, 0, 0, 0, 0, 2'b00);
      6: return mk(0, 1, p, 0, 0, 0, 0, 0, 2'b00);
      default: return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00);
    endcase
  endfunction

  // Monitor: compares every queued expectation once the outputs have settled.
  initial begin
    exp_t e;
    logic [9:0] act;
    forever begin
      wait (exp_q.size() > 0);
      #1;
      e = exp_q.pop_front();
      act = {IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt, Asel};
      checks++;
      if (outState !== e.st || act !== e.ctl) begin
        errors++;
        $display("FAIL %s: got state=%0d ctl=%b, expected state=%0d ctl=%b",
                 e.tag, outState, act, e.st, e.ctl);
      end
    end
  end

  function automatic void push(input string tag, input logic [3:0] st, input logic [9:0] ctl);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.ctl = ctl;
    exp_q.push_back(e);
  endfunction

  // phase: 0 Start, 1 Fetch, 2 Decode, 3 Execute of opcode op
  task automatic step(input string tag, input int phase, input int op,
                      input logic [2:0] ir, input logic en);
    logic [9:0] c;
    logic [3:0] s;
    @(negedge CLOCK);
    RESET = 1'b0;
    IR    = ir;
    Enter = en;
    Aeq0  = 1'($urandom_range(0, 1));
    Apos  = 1'($urandom_range(0, 1));
    case (phase)
      0: begin s = 4'd0; c = '0; end
      1: begin s = 4'd1; c = mk(1, 0, 1, 0, 0, 0, 0, 0, 2'b00); end
      2: begin s = 4'd2; c = mk(0, 0, 0, 1, 0, 0, 0, 0, 2'b00); end
      default: begin s = 4'(8 + op); c = exec_ctl(op, en, Aeq0, Apos); end
    endcase
    push(tag, s, c);
  endtask

  function automatic logic [2:0] rir();
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic do_reset(input string tag);
    @(negedge CLOCK);
    RESET = 1'b1;
    push(tag, 4'd0, '0);
  endtask

  task automatic run_instr(input int op, input int n_wait);
    step("start", 0, op, rir(), 1'($urandom_range(0, 1)));
    step("fetch", 1, op, rir(), 1'($urandom_range(0, 1)));
    step("decode", 2, op, 3'(op), 1'($urandom_range(0, 1)));
    if (op == 4) begin
      for (int i = 0; i < n_wait; i++) step("in_wait", 3, 4, rir(), 1'b0);
      step("in_enter", 3, 4, rir(), 1'b1);
    end else if (op == 7) begin
`ifdef UP_CU_HALT_RELEASE_EN
      for (int i = 0; i < 20; i++) begin
        logic en;
        en = (i == 19) ? 1'b1 : 1'($urandom_range(0, 1));
        step("halt_release", 3, 7, rir(), en);
        if (en) break;
      end
`else
      for (int i = 0; i < 20; i++) step("halt_hold", 3, 7, rir(), 1'($urandom_range(0, 1)));
      do_reset("reset_in_halt");
`endif
    end else begin
      step("exec", 3, op, rir(), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    RESET = 1'b1; IR = '0; Aeq0 = 1'b0; Apos = 1'b0; Enter = 1'b0;
    do_reset("reset_init");

    // reset asserted late in Fetch must clear state before the next edge
    step("start", 0, 0, rir(), 1'b0);
    step("fetch", 1, 0, rir(), 1'b0);
    #3;
    RESET = 1'b1;
    push("reset_mid_fetch", 4'd0, '0);

    for (int op = 0; op < 7; op++) run_instr(op, 3);
    for (int k = 0; k < 40; k++) run_instr($urandom_range(0, 6), $urandom_range(0, 4));
    run_instr(7, 0);
    for (int k = 0; k < 10; k++) run_instr($urandom_range(0, 6), $urandom_range(0, 2));

    @(negedge CLOCK);
    #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
